sleep_request_generator: RTL

SLEEP_REQUEST_GENERATOR -- requirements
Module: sleep_request_generator

---
 rtl/sleep_pkg.sv | 16 +
 rtl/sleep_request_generator_if.sv | 23 ++
 rtl/sleep_sat_counter.sv | 25 ++
 rtl/sleep_request_generator.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sleep_pkg.sv
// Shared encodings for the sleep request generator and the sleep controller it talks to.
package sleep_pkg;
  localparam int WAKE_SRC_W   = 4;
  localparam int WAKE_CAUSE_W = 5;
  localparam int CNT_W        = 8;

  localparam logic ST_ACTIVE = 1'b0;
  localparam logic ST_SLEEP  = 1'b1;

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_REQ_SLEEP = 2'd1,
    S_ASLEEP    = 2'd2,
    S_REQ_WAKE  = 2'd3
  } slp_state_e;
endpackage

// File: rtl/sleep_request_generator_if.sv
// Core/controller-facing signals of the sleep request generator.
interface sleep_request_generator_if;
  import sleep_pkg::*;

  logic                    pipeline_idle;
  logic                    sw_sleep;
  logic [WAKE_SRC_W-1:0]   wake_src;
  logic                    sleep_state_in;
  logic                    sleep_request;
  logic                    wakeup_request;
  logic [WAKE_CAUSE_W-1:0] wake_cause;
  logic                    req_timeout;

  modport slave (
    input  pipeline_idle, sw_sleep, wake_src, sleep_state_in,
    output sleep_request, wakeup_request, wake_cause, req_timeout
  );

  modport master (
    output pipeline_idle, sw_sleep, wake_src, sleep_state_in,
    input  sleep_request, wakeup_request, wake_cause, req_timeout
  );
endinterface

// File: rtl/sleep_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sleep_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                     cnt_d = '0;
    else if (inc_i && cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/sleep_request_generator.sv
// Idle/WFI driven sleep-request FSM with wake handling and ack timeout.
// Optional auto-wake timer in ASLEEP when SLEEP_WAKE_TIMER_EN is defined.
module sleep_request_generator
  import sleep_pkg::*;
#(
  parameter int IDLE_THRESHOLD = 16,
  parameter int ACK_TIMEOUT    = 8,
  parameter int WAKE_TIMER     = 1024
) (
  input logic                      clk,
  input logic                      rst,
  sleep_request_generator_if.slave bus
);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_THRESHOLD - 1);
  localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

  slp_state_e              state_q, state_d;
  logic                    sreq_q, wreq_q, to_q, to_d;
  logic [WAKE_CAUSE_W-1:0] cause_q, cause_d;
  logic [WAKE_SRC_W-1:0]   pend_q, pend_d, src_eff;
  logic [CNT_W-1:0]        idle_cnt, ack_cnt;
  logic                    tmr_fire;

  sleep_sat_counter #(.W(CNT_W)) u_idle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!bus.pipeline_idle || state_q != S_RUN || state_d != S_RUN),
    .inc_i (bus.pipeline_idle),
    .cnt_o (idle_cnt)
  );

  // Restarts on every state change, so each request phase times out independently.
  sleep_sat_counter #(.W(CNT_W)) u_ack_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_d != state_q),
    .inc_i (state_q == S_REQ_SLEEP || state_q == S_REQ_WAKE),
    .cnt_o (ack_cnt)
  );

`ifdef SLEEP_WAKE_TIMER_EN
  localparam int                TMR_W    = $clog2(WAKE_TIMER + 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WAKE_TIMER - 1);
  logic [TMR_W-1:0] tmr_q, tmr_d;

  assign tmr_d    = (state_q == S_ASLEEP) ? tmr_q + 1'b1 : '0;
  assign tmr_fire = (state_q == S_ASLEEP) && (tmr_q == TMR_LAST);

  always_ff @(posedge clk) begin
    if (rst) tmr_q <= '0;
    else     tmr_q <= tmr_d;
  end
`else
  // WAKE_TIMER is always positive, so this is a constant 0.
  assign tmr_fire = (WAKE_TIMER < 0);
`endif

  // Wakes seen while still requesting sleep are held until ASLEEP is reached.
  assign src_eff = bus.wake_src | pend_q;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    pend_d  = pend_q;
    to_d    = 1'b0;
    case (state_q)
      S_RUN: begin
        if (bus.wake_src == '0 &&
            (bus.sw_sleep || (bus.pipeline_idle && idle_cnt >= IDLE_LAST))) begin
          state_d = S_REQ_SLEEP;
          cause_d = '0;
          pend_d  = '0;
        end
      end
      S_REQ_SLEEP: begin
        pend_d = pend_q | bus.wake_src;
        if (bus.sleep_state_in == ST_SLEEP) begin
          state_d = S_ASLEEP;
        end else if (ack_cnt >= ACK_LAST) begin
          state_d = S_RUN;
          to_d    = 1'b1;
        end
      end
      S_ASLEEP: begin
        if (src_eff != '0 || tmr_fire) begin
          state_d = S_REQ_WAKE;
          cause_d = {tmr_fire, src_eff};
          pend_d  = '0;
        end
      end
      S_REQ_WAKE: begin
        if (bus.sleep_state_in == ST_ACTIVE) begin
          state_d = S_RUN;
        end else if (ack_cnt >= ACK_LAST) begin
          state_d = S_RUN;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      sreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      to_q    <= 1'b0;
      cause_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      sreq_q  <= (state_d == S_REQ_SLEEP);
      wreq_q  <= (state_d == S_REQ_WAKE);
      to_q    <= to_d;
      cause_q <= cause_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.sleep_request  = sreq_q;
  assign bus.wakeup_request = wreq_q;
  assign bus.wake_cause     = cause_q;
  assign bus.req_timeout    = to_q;
endmodule
